// File: rtl/display_pkg.sv
// Shared types, constants and the segment decoder for the display channel scheduler.
package display_pkg;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // One double-dabble iteration per input bit.
  localparam int unsigned DD_ITERATIONS = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLatch,
    StConvert,
    StUpdate
  } state_e;

  // Active-low seven-segment pattern for one BCD digit; non-decimal codes blank the digit.
  function automatic logic [6:0] bcd_to_7seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter: one shift/add-3 iteration per clock.
// Inputs are expected to be <= 9999, so four BCD digits are enough and the bit shifted
// out of the top digit is always zero.
module bin2bcd_serial
  import display_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [15:0]     bin,
  output logic [3:0][3:0] bcd,
  output logic            done
);

  localparam int unsigned CntW = $clog2(DD_ITERATIONS);

  logic [15:0]     shift_q, shift_d;
  logic [15:0]     bcd_q, bcd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            active_q, active_d;
  logic            done_q, done_d;
  logic [15:0]     adj;

  // Add-3 correction of every digit that is 5 or more before the shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state: abort wins over start; done pulses on the cycle after the last iteration.
  always_comb begin
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (abort) begin
      active_d = 1'b0;
    end else if (start) begin
      shift_d  = bin;
      bcd_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      bcd_d   = {adj[14:0], shift_q[15]};
      shift_d = {shift_q[14:0], 1'b0};
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CntW'(DD_ITERATIONS - 1)) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  // Digit [3] is thousands.
  always_comb begin
    bcd  = bcd_q;
    done = done_q;
  end

endmodule

// File: rtl/display_channel_scheduler.sv
// Time-shares the 4-digit seven-segment display between several PWM width sources.
// The displayed channel rotates every DWELL_TICKS ticks or on next_btn; each refresh
// clamps the selected width and converts it to BCD serially before updating the digits.
module display_channel_scheduler
  import display_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DWELL_TICKS  = 50,
  parameter int unsigned MAX_VALUE    = 9999
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              tick,
  input  logic [NUM_CHANNELS-1:0][15:0]     width_in,
  input  logic                              next_btn,
  input  logic                              hold,
  output logic [3:0][6:0]                   seven_seg_display,
  output logic [6:0]                        channel_seg,
  output logic [$clog2(NUM_CHANNELS)-1:0]   channel_sel,
  output logic                              busy
);

  localparam int unsigned ChW = $clog2(NUM_CHANNELS);
  localparam int unsigned DwW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [ChW-1:0] LastCh = ChW'(NUM_CHANNELS - 1);
  localparam logic [DwW-1:0] LastDw = DwW'(DWELL_TICKS - 1);
  localparam logic [15:0]    MaxVal = 16'(MAX_VALUE);

  state_e          state_q, state_d;
  logic [DwW-1:0]  dwell_q, dwell_d;
  logic [ChW-1:0]  ch_q, ch_d;
  logic            pending_q, pending_d;
  logic [ChW-1:0]  lat_ch_q;
  logic [3:0][6:0] seg_q;
  logic [6:0]      chseg_q;

  logic            dwell_expire;
  logic            advance;
  logic [15:0]     sel_width;
  logic [15:0]     clamped;
  logic            conv_start;
  logic            conv_abort;
  logic            conv_done;
  logic [3:0][3:0] conv_bcd;
  logic            update_en;

  // Channel rotation: dwell expiry and the button share one advance, so a coincident
  // pair moves the channel by exactly one.
  always_comb begin
    dwell_expire = tick && !hold && (dwell_q == LastDw);
    advance      = next_btn || dwell_expire;
    dwell_d      = dwell_q;
    ch_d         = ch_q;
    if (advance) begin
      dwell_d = '0;
      ch_d    = (ch_q == LastCh) ? '0 : ch_q + 1'b1;
    end else if (tick && !hold) begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  // Select and clamp the width of the current channel for the converter.
  always_comb begin
    sel_width = width_in[ch_q];
    clamped   = (sel_width > MaxVal) ? MaxVal : sel_width;
  end

  // FSM state register plus the rotation and pending-refresh state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      dwell_q   <= '0;
      ch_q      <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      ch_q      <= ch_d;
      pending_q <= pending_d;
    end
  end

  // FSM next-state and single-entry refresh queue.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      StIdle: begin
        if (tick || advance || pending_q) state_d = StLatch;
      end
      StLatch: begin
        // Width is captured now; a channel change this cycle needs a fresh refresh.
        pending_d = tick || advance;
        state_d   = StConvert;
      end
      StConvert: begin
        if (tick) pending_d = 1'b1;
        if (advance) begin
          state_d = StLatch;
        end else if (conv_done) begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        if (tick || advance) pending_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: converter control and display write enable.
  always_comb begin
    busy       = 1'b0;
    conv_start = 1'b0;
    conv_abort = 1'b0;
    update_en  = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLatch: begin
        busy       = 1'b1;
        conv_start = 1'b1;
      end
      StConvert: begin
        busy       = 1'b1;
        conv_abort = advance;
      end
      StUpdate: begin
        busy      = 1'b1;
        update_en = 1'b1;
      end
      default: ;
    endcase
  end

  bin2bcd_serial u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .abort (conv_abort),
    .bin   (clamped),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // Display registers: value and channel digit are written together so they always match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_ch_q <= '0;
      seg_q    <= {4{SEG_BLANK}};
      chseg_q  <= SEG_BLANK;
    end else begin
      if (conv_start) lat_ch_q <= ch_q;
      if (update_en) begin
        for (int i = 0; i < 4; i++) begin
          seg_q[i] <= bcd_to_7seg(conv_bcd[i]);
        end
        chseg_q <= bcd_to_7seg(4'(lat_ch_q));
      end
    end
  end

  // Drive outputs from registers.
  always_comb begin
    seven_seg_display = seg_q;
    channel_seg       = chseg_q;
    channel_sel       = ch_q;
  end

endmodule

// File: tb/tb_display_channel_scheduler.sv
// Directed bench for display_channel_scheduler with a scoreboard of expected display updates.
module tb_display_channel_scheduler;

  localparam int unsigned NCH = 3;
  localparam int unsigned DW  = 4;

  logic                 clk;
  logic                 reset;
  logic                 tick;
  logic [NCH-1:0][15:0] width_in;
  logic                 next_btn;
  logic                 hold;
  logic [3:0][6:0]      seven_seg_display;
  logic [6:0]           channel_seg;
  logic [1:0]           channel_sel;
  logic                 busy;

  typedef struct {
    logic [27:0] seg;
    logic [6:0]  ch;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp;
  int          n_fail;
  logic [27:0] forbid;
  bit          use_forbid;
  bit          saw_forbid;
  bit          saw_busy;

  display_channel_scheduler #(
    .NUM_CHANNELS (NCH),
    .DWELL_TICKS  (DW),
    .MAX_VALUE    (9999)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .tick              (tick),
    .width_in          (width_in),
    .next_btn          (next_btn),
    .hold              (hold),
    .seven_seg_display (seven_seg_display),
    .channel_seg       (channel_seg),
    .channel_sel       (channel_sel),
    .busy              (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] mk_seg(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {seg_of((c / 1000) % 10), seg_of((c / 100) % 10), seg_of((c / 10) % 10),
            seg_of(c % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int v, input int ch, input int lat);
    exp_t e;
    e.seg = mk_seg(v);
    e.ch  = seg_of(ch);
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic pulse_next();
    next_btn = 1'b1;
    step();
    next_btn = 1'b0;
  endtask

  // Wait for the next display update (busy falling) and compare against the scoreboard head.
  task automatic check_next(input string tag);
    exp_t e;
    int   n;
    e = sb.pop_front();
    n = 0;
    saw_forbid = 1'b0;
    do begin
      step();
      n++;
      if (use_forbid && seven_seg_display === forbid) saw_forbid = 1'b1;
    end while (busy !== 1'b0 && n < 200);
    check({tag, "/done"}, 32'(busy), 32'(0));
    if (e.lat != 0) check({tag, "/lat"}, 32'(n), 32'(e.lat));
    check({tag, "/seg"}, 32'(seven_seg_display), 32'(e.seg));
    check({tag, "/chseg"}, 32'(channel_seg), 32'(e.ch));
    if (use_forbid) check({tag, "/stale"}, 32'(saw_forbid), 32'(0));
  endtask

  initial begin
    int c;
    n_cmp      = 0;
    n_fail     = 0;
    reset      = 1'b1;
    tick       = 1'b0;
    next_btn   = 1'b0;
    hold       = 1'b1;
    width_in   = '0;
    use_forbid = 1'b0;
    forbid     = '0;
    step();
    step();
    check("rst_seg", 32'(seven_seg_display), 32'h0fffffff);
    check("rst_chseg", 32'(channel_seg), 32'h7f);
    check("rst_sel", 32'(channel_sel), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));

    // Test 1: refreshes, then asynchronous reset in the middle of a conversion.
    width_in[0] = 16'd1500;
    width_in[1] = 16'd2222;
    width_in[2] = 16'd777;
    reset = 1'b0;
    step();
    pulse_tick();
    push(1500, 0, 19);
    check_next("t1_first");
    pulse_next();
    push(2222, 1, 19);
    check_next("t1_ch1");
    check("t1_sel1", 32'(channel_sel), 32'(1));
    pulse_tick();
    repeat (8) step();
    #2 reset = 1'b1;
    #1;
    check("t1_async_seg", 32'(seven_seg_display), 32'h0fffffff);
    check("t1_async_chseg", 32'(channel_seg), 32'h7f);
    check("t1_async_sel", 32'(channel_sel), 32'(0));
    check("t1_async_busy", 32'(busy), 32'(0));
    step();
    reset = 1'b0;
    step();
    pulse_tick();
    push(1500, 0, 19);
    check_next("t1_after_rst");

    // Test 2: clamp and leading zeros.
    width_in[0] = 16'd12345;
    pulse_tick();
    push(12345, 0, 19);
    check_next("t2_clamp");
    width_in[0] = 16'd0;
    pulse_tick();
    push(0, 0, 19);
    check_next("t2_zero");

    // Test 3: auto-rotation every DW ticks, then frozen by hold.
    hold = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      pulse_tick();
      c = (k / 4) % 3;
      check($sformatf("t3_sel_%0d", k), 32'(channel_sel), 32'(c));
      push(int'(width_in[c]), c, 19);
      check_next($sformatf("t3_disp_%0d", k));
    end
    hold = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      pulse_tick();
      check($sformatf("t3_hold_sel_%0d", k), 32'(channel_sel), 32'(0));
      push(int'(width_in[0]), 0, 19);
      check_next($sformatf("t3_hold_disp_%0d", k));
    end

    // Test 4: button coincident with dwell expiry, and button restarting the dwell count.
    hold = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) next_btn = 1'b1;
      pulse_tick();
      next_btn = 1'b0;
      c = (k < 4) ? 0 : ((k < 8) ? 1 : 2);
      check($sformatf("t4_sel_%0d", k), 32'(channel_sel), 32'(c));
      push(int'(width_in[c]), c, 19);
      check_next($sformatf("t4_disp_%0d", k));
    end
    for (int k = 1; k <= 2; k++) begin
      pulse_tick();
      push(int'(width_in[2]), 2, 19);
      check_next($sformatf("t4_pre_%0d", k));
    end
    pulse_next();
    check("t4_btn_sel", 32'(channel_sel), 32'(0));
    push(int'(width_in[0]), 0, 19);
    check_next("t4_btn_disp");
    for (int k = 1; k <= 4; k++) begin
      pulse_tick();
      c = (k == 4) ? 1 : 0;
      check($sformatf("t4_restart_sel_%0d", k), 32'(channel_sel), 32'(c));
      push(int'(width_in[c]), c, 19);
      check_next($sformatf("t4_restart_disp_%0d", k));
    end

    // Test 5: channel change in CONVERT aborts; stale value never reaches the display.
    hold = 1'b1;
    pulse_next();
    push(777, 2, 19);
    check_next("t5_to_ch2");
    pulse_next();
    push(0, 0, 19);
    check_next("t5_to_ch0");
    width_in[0] = 16'd1111;
    width_in[1] = 16'd2222;
    pulse_tick();
    repeat (5) step();
    pulse_next();
    push(2222, 1, 19);
    forbid     = mk_seg(1111);
    use_forbid = 1'b1;
    check_next("t5_abort");
    use_forbid = 1'b0;
    check("t5_sel", 32'(channel_sel), 32'(1));

    // Test 6: ticks while busy queue exactly one extra refresh, sampling width only in LATCH.
    pulse_tick();
    step();
    width_in[1] = 16'd3456;
    step();
    step();
    pulse_tick();
    repeat (3) step();
    pulse_tick();
    repeat (3) step();
    pulse_tick();
    push(2222, 1, 0);
    push(3456, 1, 0);
    check_next("t6_first");
    step();
    check("t6_extra_busy", 32'(busy), 32'(1));
    check_next("t6_second");
    saw_busy = 1'b0;
    repeat (40) begin
      step();
      if (busy) saw_busy = 1'b1;
    end
    check("t6_no_third", 32'(saw_busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
